// File: rtl/fir_tap_feeder.sv
// Serial-to-parallel 10-tap delay line with priming and integer decimation for the FIR adder tree.
// Optional macro FIR_TAP_FEEDER_SUM_VALID_EN adds sum_valid, taps_valid delayed by TREE_LATENCY cycles.
module fir_tap_feeder #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned DECIM        = 1,
  parameter int unsigned TREE_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic signed [DATA_WIDTH-1:0] tap0,
  output logic signed [DATA_WIDTH-1:0] tap1,
  output logic signed [DATA_WIDTH-1:0] tap2,
  output logic signed [DATA_WIDTH-1:0] tap3,
  output logic signed [DATA_WIDTH-1:0] tap4,
  output logic signed [DATA_WIDTH-1:0] tap5,
  output logic signed [DATA_WIDTH-1:0] tap6,
  output logic signed [DATA_WIDTH-1:0] tap7,
  output logic signed [DATA_WIDTH-1:0] tap8,
  output logic signed [DATA_WIDTH-1:0] tap9,
  output logic                         taps_valid,
  output logic                         primed
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
  ,
  output logic                         sum_valid
`endif
);

  localparam int unsigned TAPS    = 10;
  localparam int unsigned FILL_W  = 4;
  localparam int unsigned PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(TAPS);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  if (DECIM < 1 || DECIM > 16 || TREE_LATENCY < 1) begin : g_bad_cfg
    $error("fir_tap_feeder: DECIM must be 1..16 and TREE_LATENCY >= 1");
  end

  logic [DATA_WIDTH-1:0] taps_q [TAPS];
  logic [DATA_WIDTH-1:0] taps_d [TAPS];
  logic [FILL_W-1:0]     fill_q, fill_d, fill_inc;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  taps_valid_q, taps_valid_d;
  logic                  primed_q, primed_d;

  // Next-state: flush clears, accepted sample shifts and advances fill/phase, idle holds.
  always_comb begin
    taps_d       = taps_q;
    fill_d       = fill_q;
    phase_d      = phase_q;
    taps_valid_d = 1'b0;
    fill_inc     = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

    if (flush) begin
      for (int k = 0; k < TAPS; k++) taps_d[k] = '0;
      fill_d  = '0;
      phase_d = '0;
    end else if (in_valid) begin
      taps_d[0] = in_data;
      for (int k = 1; k < TAPS; k++) taps_d[k] = taps_q[k-1];
      fill_d = fill_inc;
      if (fill_inc == FILL_FULL) begin
        taps_valid_d = (phase_q == '0);
        phase_d      = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
      end else begin
        phase_d = '0;
      end
    end
    primed_d = (fill_d == FILL_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
      fill_q       <= '0;
      phase_q      <= '0;
      taps_valid_q <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) taps_q[k] <= taps_d[k];
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      taps_valid_q <= taps_valid_d;
      primed_q     <= primed_d;
    end
  end

  assign tap0       = taps_q[0];
  assign tap1       = taps_q[1];
  assign tap2       = taps_q[2];
  assign tap3       = taps_q[3];
  assign tap4       = taps_q[4];
  assign tap5       = taps_q[5];
  assign tap6       = taps_q[6];
  assign tap7       = taps_q[7];
  assign tap8       = taps_q[8];
  assign tap9       = taps_q[9];
  assign taps_valid = taps_valid_q;
  assign primed     = primed_q;

`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
  // Valid pipe matching the adder tree; flush leaves in-flight windows alone.
  logic [TREE_LATENCY-1:0] sv_pipe_q, sv_pipe_d;

  always_comb begin
    sv_pipe_d    = sv_pipe_q;
    sv_pipe_d[0] = taps_valid_q;
    for (int i = 1; i < TREE_LATENCY; i++) sv_pipe_d[i] = sv_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) sv_pipe_q <= '0;
    else     sv_pipe_q <= sv_pipe_d;
  end

  assign sum_valid = sv_pipe_q[TREE_LATENCY-1];
`endif

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Self-checking bench: DECIM=1 and DECIM=3 instances share stimulus and are checked every cycle
// against a sample-history model, plus directed table and corner-case sequences.
module tb_fir_tap_feeder;

  localparam int unsigned DW = 18;
  localparam int unsigned TL = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] t0;
    logic [DW-1:0] t9;
    logic          tv1;
    logic          tv3;
    logic          pr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, flush, in_valid;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] a_tap [10];
  logic signed [DW-1:0] b_tap [10];
  logic                 a_tv, a_pr, b_tv, b_pr;
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
  logic                 a_sv, b_sv;
  bit                   sq1[$], sq3[$];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] hist[$];
  int            n_acc = 0;

  fir_tap_feeder #(.DATA_WIDTH(DW), .DECIM(1), .TREE_LATENCY(TL)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap0(a_tap[0]), .tap1(a_tap[1]), .tap2(a_tap[2]), .tap3(a_tap[3]), .tap4(a_tap[4]),
    .tap5(a_tap[5]), .tap6(a_tap[6]), .tap7(a_tap[7]), .tap8(a_tap[8]), .tap9(a_tap[9]),
    .taps_valid(a_tv), .primed(a_pr)
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    , .sum_valid(a_sv)
`endif
  );

  fir_tap_feeder #(.DATA_WIDTH(DW), .DECIM(3), .TREE_LATENCY(TL)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .tap0(b_tap[0]), .tap1(b_tap[1]), .tap2(b_tap[2]), .tap3(b_tap[3]), .tap4(b_tap[4]),
    .tap5(b_tap[5]), .tap6(b_tap[6]), .tap7(b_tap[7]), .tap8(b_tap[8]), .tap9(b_tap[9]),
    .taps_valid(b_tv), .primed(b_pr)
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    , .sum_valid(b_sv)
`endif
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, advance the model, compare every output of both instances.
  task automatic step(input logic r, input logic f, input logic v, input logic [DW-1:0] d);
    logic mv1, mv3;
    logic [DW-1:0] et;
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    bit es1, es3;
`endif
    rst = r; flush = f; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    mv1 = 1'b0;
    mv3 = 1'b0;
    if (r || f) begin
      hist.delete();
      n_acc = 0;
    end else if (v) begin
      hist.push_front(d);
      if (hist.size() > 10) void'(hist.pop_back());
      n_acc++;
      if (n_acc >= 10) begin
        mv1 = 1'b1;
        mv3 = ((n_acc - 10) % 3) == 0;
      end
    end
    for (int k = 0; k < 10; k++) begin
      et = (k < hist.size()) ? hist[k] : '0;
      chk($sformatf("d1_tap%0d", k), a_tap[k], et);
      chk($sformatf("d3_tap%0d", k), b_tap[k], et);
    end
    chk("d1_taps_valid", DW'(a_tv), DW'(mv1));
    chk("d3_taps_valid", DW'(b_tv), DW'(mv3));
    chk("d1_primed", DW'(a_pr), DW'(n_acc >= 10));
    chk("d3_primed", DW'(b_pr), DW'(n_acc >= 10));
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    es1 = r ? 1'b0 : sq1[TL-1];
    es3 = r ? 1'b0 : sq3[TL-1];
    void'(sq1.pop_back()); sq1.push_front(mv1);
    void'(sq3.pop_back()); sq3.push_front(mv3);
    if (r) for (int k = 0; k < TL; k++) begin sq1[k] = 1'b0; sq3[k] = 1'b0; end
    chk("d1_sum_valid", DW'(a_sv), DW'(es1));
    chk("d3_sum_valid", DW'(b_sv), DW'(es3));
`endif
  endtask

  initial begin
    vec_t          tbl [11];
    logic [DW-1:0] pulses[$];
    int            cnt;

    for (int i = 0; i < 11; i++) begin
      tbl[i].d   = DW'(i + 1);
      tbl[i].t0  = DW'(i + 1);
      tbl[i].t9  = (i >= 9) ? DW'(i - 8) : '0;
      tbl[i].tv1 = (i >= 9);
      tbl[i].tv3 = (i == 9);
      tbl[i].pr  = (i >= 9);
    end
`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    for (int k = 0; k < TL; k++) begin sq1.push_back(1'b0); sq3.push_back(1'b0); end
`endif

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, DW'(55));
    chk("rst_tap0", a_tap[0], '0);
    chk("rst_taps_valid", DW'(a_tv), '0);
    chk("rst_primed", DW'(b_pr), '0);

    // Contiguous 1..11: first window on sample 10.
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0, 1'b1, tbl[i].d);
      chk("tbl_tap0", a_tap[0], tbl[i].t0);
      chk("tbl_tap9", a_tap[9], tbl[i].t9);
      chk("tbl_tv_d1", DW'(a_tv), DW'(tbl[i].tv1));
      chk("tbl_tv_d3", DW'(b_tv), DW'(tbl[i].tv3));
      chk("tbl_primed", DW'(a_pr), DW'(tbl[i].pr));
    end

    // DECIM=3 over 1..20: windows end at 10, 13, 16, 19.
    step(1'b0, 1'b1, 1'b0, '0);
    for (int s = 1; s <= 20; s++) begin
      step(1'b0, 1'b0, 1'b1, DW'(s));
      if (b_tv) pulses.push_back(b_tap[0]);
    end
    chk("d3_pulse_count", DW'(pulses.size()), DW'(4));
    for (int k = 0; k < pulses.size() && k < 4; k++) chk("d3_pulse_tap0", pulses[k], DW'(10 + 3 * k));

    // Gapped input: three idle cycles after each sample.
    step(1'b0, 1'b1, 1'b0, '0);
    cnt = 0;
    for (int s = 1; s <= 10; s++) begin
      step(1'b0, 1'b0, 1'b1, DW'(s));
      if (a_tv) cnt++;
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0, DW'(77));
        if (a_tv) cnt++;
      end
    end
    chk("gap_pulse_count", DW'(cnt), DW'(1));
    chk("gap_tap0_hold", a_tap[0], DW'(10));
    chk("gap_tap9_hold", a_tap[9], DW'(1));

    // Flush mid-fill, then a fresh window.
    for (int s = 1; s <= 7; s++) step(1'b0, 1'b0, 1'b1, DW'(s + 40));
    step(1'b0, 1'b1, 1'b0, '0);
    chk("flush_tap0", a_tap[0], '0);
    chk("flush_tap6", a_tap[6], '0);
    chk("flush_primed", DW'(a_pr), '0);
    for (int s = 101; s <= 110; s++) step(1'b0, 1'b0, 1'b1, DW'(s));
    chk("refill_tap0", a_tap[0], DW'(110));
    chk("refill_tap9", a_tap[9], DW'(101));
    chk("refill_valid", DW'(a_tv), DW'(1));

    // Flush wins over a same-cycle sample.
    step(1'b0, 1'b1, 1'b1, DW'(999));
    step(1'b0, 1'b0, 1'b1, DW'(5));
    chk("flushv_tap0", a_tap[0], DW'(5));
    chk("flushv_tap1", a_tap[1], '0);

    // Full-scale extremes pass bit-exact.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, (i % 2) ? 18'h1FFFF : 18'h20000);
    chk("fs_tap0", a_tap[0], 18'h1FFFF);
    chk("fs_tap1", a_tap[1], 18'h20000);
    chk("fs_tap9", b_tap[9], 18'h20000);

    // Reset mid-stream clears everything.
    step(1'b1, 1'b0, 1'b1, DW'(7));
    chk("rstmid_tap0", a_tap[0], '0);
    chk("rstmid_tap9", b_tap[9], '0);
    chk("rstmid_primed", DW'(a_pr), '0);
    chk("rstmid_valid", DW'(a_tv), '0);

`ifdef FIR_TAP_FEEDER_SUM_VALID_EN
    // Flush after a pulse keeps the in-flight sum_valid; reset kills it.
    for (int s = 1; s <= 10; s++) step(1'b0, 1'b0, 1'b1, DW'(s));
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("sv_after_flush", DW'(a_sv), DW'(1));
    for (int s = 1; s <= 10; s++) step(1'b0, 1'b0, 1'b1, DW'(s));
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("sv_after_rst", DW'(a_sv), '0);
`endif

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
